// File: rtl/fetch.sv
// Instruction fetch stage.
// Owns the program counter, issues single-outstanding word reads to instruction
// memory, buffers the returned word and hands it to decode over valid/ready.
// Redirects squash any in-flight or held instruction; a target with bit 1 set
// is reported as a misaligned-fetch fault instead of being fetched.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_req/imem_addr   read request and word address (held until imem_ack)
//   imem_ack/imem_rdata  read completion and instruction word
//   redirect/redirect_pc one-cycle flow change and its target (bit 0 ignored)
//   ins/pc/pc_4          instruction to decode, its address, address + 4
//   ins_valid/ins_ready  decode handshake
//   ins_fault            instruction-address-misaligned (ins = 0 when set)
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic        ins_fault
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrop, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] ins_buf_q, ins_buf_d;
  logic [31:0] pc_buf_q, pc_buf_d;
  logic        fault_buf_q, fault_buf_d;

  logic [31:0] tgt;       // redirect target with bit 0 cleared
  logic [31:0] drop_tgt;  // newest target when the dropped request completes
  logic        fault_en;
  logic [31:0] fault_pc;

  assign tgt      = redirect_pc & ~32'h1;
  assign drop_tgt = redirect ? tgt : pending_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    ins_buf_d    = ins_buf_q;
    pc_buf_d     = pc_buf_q;
    fault_buf_d  = fault_buf_q;
    fault_en     = 1'b0;
    fault_pc     = tgt;

    unique case (state_q)
      StIdle: begin
        // A redirect here behaves like FETCH without an ack.
        if (redirect) begin
          pending_pc_d = tgt;
          state_d      = StDrop;
        end else begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ack) begin
          if (redirect) begin
            // Returned word belongs to the old flow; discard it.
            if (tgt[1]) begin
              fault_en = 1'b1;
            end else begin
              fetch_pc_d = tgt;
            end
          end else begin
            ins_buf_d   = imem_rdata;
            pc_buf_d    = fetch_pc_q;
            fault_buf_d = 1'b0;
            fetch_pc_d  = fetch_pc_q + 32'd4;
            state_d     = StHold;
          end
        end else if (redirect) begin
          // Address must stay stable until the pending read completes.
          pending_pc_d = tgt;
          state_d      = StDrop;
        end
      end
      StDrop: begin
        if (redirect) begin
          pending_pc_d = tgt;
        end
        if (imem_ack) begin
          if (drop_tgt[1]) begin
            fault_en = 1'b1;
            fault_pc = drop_tgt;
          end else begin
            fetch_pc_d = drop_tgt;
            state_d    = StFetch;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          // Squash the held word even if decode is ready this cycle.
          if (tgt[1]) begin
            fault_en = 1'b1;
          end else begin
            fetch_pc_d = tgt;
            state_d    = StFetch;
          end
        end else if (ins_ready) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Misaligned target: present a fault without touching memory.
    if (fault_en) begin
      pc_buf_d    = fault_pc;
      ins_buf_d   = 32'h0;
      fault_buf_d = 1'b1;
      fetch_pc_d  = fault_pc & ~32'h3;
      state_d     = StHold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 32'h0;
      ins_buf_q    <= 32'h0;
      pc_buf_q     <= 32'h0;
      fault_buf_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      ins_buf_q    <= ins_buf_d;
      pc_buf_q     <= pc_buf_d;
      fault_buf_q  <= fault_buf_d;
    end
  end

  assign imem_req  = (state_q == StFetch) || (state_q == StDrop);
  assign imem_addr = fetch_pc_q;
  assign ins_valid = (state_q == StHold);
  assign ins       = ins_buf_q;
  assign pc        = pc_buf_q;
  assign pc_4      = pc_buf_q + 32'd4;
  assign ins_fault = fault_buf_q;

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        ins_valid;
  logic        ins_ready;
  logic        ins_fault;

  // Memory model: acks after wait_states idle request cycles, data = addr ^ A5A5_0000.
  int          wait_states;
  int          mem_cnt;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        man_en;
  logic        man_ack;

  int n_cmp;
  int n_err;
  int xfer_cnt;

  fetch #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ins        (ins),
    .pc         (pc),
    .pc_4       (pc_4),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_fault  (ins_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = man_en ? man_ack : mem_ack;
  assign imem_rdata = mem_rdata;

  initial begin
    mem_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    xfer_cnt  = 0;
  end

  always @(negedge clk) begin
    if (rst || !imem_req) begin
      mem_cnt <= 0;
      mem_ack <= 1'b0;
    end else if (mem_cnt >= wait_states) begin
      mem_ack   <= 1'b1;
      mem_rdata <= imem_addr ^ 32'hA5A5_0000;
      mem_cnt   <= 0;
    end else begin
      mem_ack <= 1'b0;
      mem_cnt <= mem_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready && !redirect) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req),  32'd0);
    check({tag, "_valid"}, 32'(ins_valid), 32'd0);
    check({tag, "_ins"},   ins,            32'h0);
    check({tag, "_pc"},    pc,             32'h0);
    check({tag, "_pc4"},   pc_4,           32'h4);
    check({tag, "_fault"}, 32'(ins_fault), 32'd0);
    check({tag, "_addr"},  imem_addr,      32'h100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          x0;
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ins_ready   = 1'b1;
    wait_states = 0;
    man_en      = 1'b0;
    man_ack     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);

    // Zero-wait streaming with ins_ready high; last word meets backpressure.
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(4 * i);
      tick();
      check("str_req", 32'(imem_req), 32'd1);
      check("str_addr", imem_addr, a);
      check("str_valid_lo", 32'(ins_valid), 32'd0);
      if (i == 2) ins_ready = 1'b0;
      tick();
      check("str_valid", 32'(ins_valid), 32'd1);
      check("str_ins", ins, a ^ 32'hA5A5_0000);
      check("str_pc", pc, a);
      check("str_pc4", pc_4, a + 32'd4);
      check("str_fault", 32'(ins_fault), 32'd0);
    end

    // Backpressure: held word stable, no request.
    repeat (5) begin
      tick();
      check("bp_valid", 32'(ins_valid), 32'd1);
      check("bp_ins", ins, 32'hA5A5_0108);
      check("bp_pc", pc, 32'h108);
      check("bp_req", 32'(imem_req), 32'd0);
    end
    ins_ready = 1'b1;
    tick();
    check("bp_xfer", 32'(xfer_cnt), 32'd3);
    check("bp_next_addr", imem_addr, 32'h10C);
    check("bp_next_req", 32'(imem_req), 32'd1);

    // Redirect during a 3-wait-state request to 0x104.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rd_first_addr", imem_addr, 32'h100);
    tick();
    check("rd_first_pc", pc, 32'h100);
    wait_states = 3;
    tick();
    check("rd_addr104", imem_addr, 32'h104);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tick();
      redirect = 1'b0;
      check("rd_hold_req", 32'(imem_req), 32'd1);
      check("rd_hold_addr", imem_addr, 32'h104);
      check("rd_no_valid", 32'(ins_valid), 32'd0);
    end
    tick();
    check("rd_new_req", 32'(imem_req), 32'd1);
    check("rd_new_addr", imem_addr, 32'h200);
    check("rd_new_valid", 32'(ins_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h280;
    tick();
    check("rd2_addr_a", imem_addr, 32'h200);
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("rd2_addr_b", imem_addr, 32'h200);
    tick();
    check("rd2_addr_c", imem_addr, 32'h200);
    tick();
    check("rd2_last_wins", imem_addr, 32'h300);
    check("rd2_req", 32'(imem_req), 32'd1);
    wait_states = 0;
    tick();
    check("rd2_ins", ins, 32'hA5A5_0300);
    check("rd2_pc", pc, 32'h300);

    // Redirect in HOLD with ins_ready high: squashed, bit 0 ignored.
    x0          = xfer_cnt;
    redirect    = 1'b1;
    redirect_pc = 32'h41;
    tick();
    redirect = 1'b0;
    check("hr_addr", imem_addr, 32'h40);
    check("hr_req", 32'(imem_req), 32'd1);
    check("hr_no_xfer", 32'(xfer_cnt), 32'(x0));
    tick();
    check("hr_pc", pc, 32'h40);
    check("hr_ins", ins, 32'hA5A5_0040);

    // Misaligned redirect: fault without a memory request.
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    ins_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    check("mis_valid", 32'(ins_valid), 32'd1);
    check("mis_fault", 32'(ins_fault), 32'd1);
    check("mis_pc", pc, 32'h102);
    check("mis_ins", ins, 32'h0);
    check("mis_req", 32'(imem_req), 32'd0);
    check("mis_pc4", pc_4, 32'h106);
    tick();
    check("mis_req2", 32'(imem_req), 32'd0);
    ins_ready = 1'b1;
    tick();
    check("mis_next_addr", imem_addr, 32'h100);
    tick();
    check("mis_next_fault", 32'(ins_fault), 32'd0);
    check("mis_next_pc", pc, 32'h100);

    // Wrap-around at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_4, 32'h0);
    check("wrap_ins", ins, 32'h5A5A_FFFC);
    tick();
    check("wrap_next_addr", imem_addr, 32'h0);
    tick();
    check("wrap_next_pc", pc, 32'h0);

    // Reset mid-request at 0x104; late ack after release is ignored.
    man_en      = 1'b1;
    man_ack     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    tick();
    redirect = 1'b0;
    check("mr_addr", imem_addr, 32'h104);
    tick();
    check("mr_addr2", imem_addr, 32'h104);
    rst = 1'b1;
    #1;
    check_reset_outputs("mr_rst");
    tick();
    rst     = 1'b0;
    man_ack = 1'b1;
    tick();
    check("mr_late_ack_valid", 32'(ins_valid), 32'd0);
    check("mr_req", 32'(imem_req), 32'd1);
    check("mr_first_addr", imem_addr, 32'h100);
    man_en  = 1'b0;
    man_ack = 1'b0;
    tick();
    check("mr_valid", 32'(ins_valid), 32'd1);
    check("mr_pc", pc, 32'h100);
    check("mr_ins", ins, 32'hA5A5_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage: owns the program counter and issues word reads to instruction memory with a single outstanding request. It holds each returned word in an output register and presents it to the decode stage over a valid/ready handshake. Redirects from the jump unit squash any in-flight or held instruction; a misaligned redirect target is reported as a fetch fault instead of being fetched.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_req`  out  1  read request; held until `imem_ack`.
- `imem_addr`  out  32  word address, stable while `imem_req` is high; bits [1:0] always 0.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle. Sampled only while `imem_req` is high; may assert in the same cycle `imem_req` first rises.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  one-cycle pulse: change flow to `redirect_pc`.
- `redirect_pc`  in  32  target; bit 0 ignored (treated as 0).
- `ins`  out  32  instruction to decode.
- `pc`  out  32  address of `ins`.
- `pc_4`  out  32  `pc + 4`, mod 2^32.
- `ins_valid`  out  1  `ins`/`pc`/`ins_fault` valid.
- `ins_ready`  in  1  decode accepts.
- `ins_fault`  out  1  instruction-address-misaligned; `ins` = 0 when set.

## Operation
- Registers: `state`, `fetch_pc`, `pending_pc`, `ins_buf`, `pc_buf`, `fault_buf`.
- States: IDLE, FETCH, DROP, HOLD. Outputs: `imem_req` = (FETCH or DROP); `imem_addr` = `fetch_pc`; `ins_valid` = HOLD; `ins`/`pc`/`ins_fault` = buffer registers.
- Transfer to decode = `ins_valid && ins_ready && !redirect`.
- Redirect target classification: `t = {redirect_pc[31:1],1'b0}`. If `t[1]` = 1, the target is misaligned.
- IDLE: go to FETCH unconditionally. If `redirect` is asserted, it is applied as in FETCH with no ack.
- FETCH:
  - ack, no redirect: `ins_buf`←`imem_rdata`, `pc_buf`←`fetch_pc`, `fault_buf`←0, `fetch_pc`+=4 (wraps), go to HOLD.
  - ack with redirect: discard the data. Aligned target: `fetch_pc`←`t`, stay in FETCH. Misaligned target: load fault (see below).
  - redirect without ack: `pending_pc`←`t`, go to DROP. The address is not changed while the request is pending.
  - neither: stay in FETCH.
- DROP: keep the request and address. Any redirect overwrites `pending_pc` (last one wins). On ack: discard the data, `fetch_pc`←newest target (`redirect` this cycle, else `pending_pc`), go to FETCH. If that target is misaligned, load fault instead.
- HOLD:
  - redirect: the held instruction is squashed even if `ins_ready` = 1. Aligned target: `fetch_pc`←`t`, go to FETCH. Misaligned target: load fault.
  - transfer: go to FETCH.
  - else: stay in HOLD; buffers stable.
- Load fault (misaligned target): no imem request is issued. `pc_buf`←`t`, `ins_buf`←0, `fault_buf`←1, `fetch_pc`←`t & ~3`, go to HOLD.
- Reset (asynchronous, any state, including mid-request): `state`=IDLE, `fetch_pc`=`RESET_PC`, `pending_pc`=0, `ins_buf`=0, `pc_buf`=0, `fault_buf`=0.
  - Outputs during reset: `imem_req`=0, `ins_valid`=0, `ins`=0, `pc`=0, `pc_4`=4, `ins_fault`=0, `imem_addr`=`RESET_PC`.
  - An ack for a request abandoned by reset arrives while in IDLE and is ignored. The memory must drop outstanding requests on `rst`.

## Timing
- First `imem_req` is in the second cycle after `rst` deasserts (IDLE for 1 cycle).
- Latency: ack in cycle N → `ins_valid` in cycle N+1 (registered output); no combinational path from `imem_rdata` to `ins`.
- Zero-wait memory (ack in the first request cycle): one instruction every 2 cycles with `ins_ready` held high.
- Redirect → new `imem_addr` on `imem_req` in the next cycle, except in DROP/FETCH-without-ack, where it waits for the pending ack.
- `ins_ready` → `ins_valid` is combinational only through `state`. `redirect` → transfer is combinational: decode must qualify acceptance with `!redirect`.
- `imem_addr` never changes while `imem_req`=1 and no ack has been seen.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory returning addr^0xA5A5_0000, `ins_ready`=1:
  - `imem_req` rises 2 cycles after reset release.
  - Addresses 0x100, 0x104, 0x108.
  - `ins` = 0xA5A5_0100, … valid every 2 cycles; `pc_4` = `pc`+4.
- Backpressure: `ins_ready`=0 for 5 cycles in HOLD → `ins`/`pc` stable, `imem_req`=0; then ready=1 → single transfer, next fetch at `pc`+4.
- Redirect to 0x200 while a 3-wait-state request to 0x104 is pending:
  - `imem_addr` stays 0x104 until ack; that data is never valid.
  - Next request is 0x200.
  - A second redirect to 0x300 in DROP wins (next address 0x300).
- Redirect in HOLD with `ins_ready`=1 → no transfer counted; next `imem_addr`=0x40 for `redirect_pc`=0x41 (bit 0 ignored).
- Redirect to 0x102 → no imem request; `ins_valid`=1, `ins_fault`=1, `pc`=0x102, `ins`=0.
- Assert `rst` mid-request at 0x104 with a late ack after release → all outputs at reset values; the late ack is ignored; first valid `pc` = `RESET_PC`.
- Wrap: redirect to 0xFFFF_FFFC → `pc_4`=0, next fetch address 0x0.
